// File: rtl/up_sample_sched_ctrl.sv
// up_sample_sched_ctrl: sequences the frame-sized input buffer for the up-sample pipeline.
//   It generates write enables and addresses for the incoming pixel stream and nearest-neighbor
//   read requests at the up-scaled resolution.
// Latency: in_wen/out_ren are combinational from the registered state and the current inputs.
//   A row becomes readable the cycle after its last write. done pulses one cycle after the final access.
// Backpressure: in_ready drops once the frame is fully written. out_ren requires out_ready, and
//   out_ctrl_vars hold while a read is stalled.
//
// Ports:
//   clk, rst (async, active-high), flush (sync restart), start (IDLE only)
//   in_valid/in_ready/in_wen : write handshake, in_wen = in_valid & in_ready
//   in_ctrl_vars  [47:0]     : {[47:32]=input col, [31:16]=input row, [15:0]=0}
//   out_ready/out_ren        : read handshake
//   out_ctrl_vars [47:0]     : {[47:32]=output col, [31:16]=output row, [15:0]=0}
//   busy (RUN), done (one-cycle pulse in DONE)
//
// Build option UPSAMPLE_SCHED_OVERLAP_EN: when defined, reads overlap writes and are gated row by row.
//   When undefined, no read is issued until the whole frame has been written.
module up_sample_sched_ctrl #(
  parameter int IN_W       = 64,
  parameter int IN_H       = 64,
  parameter int SCALE_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        in_wen,
  output logic [47:0] in_ctrl_vars,
  input  logic        out_ready,
  output logic        out_ren,
  output logic [47:0] out_ctrl_vars,
  output logic        busy,
  output logic        done
);

  localparam int OUT_W = IN_W << SCALE_LOG2;
  localparam int OUT_H = IN_H << SCALE_LOG2;
  localparam logic [15:0] WX_LAST = 16'(IN_W - 1);
  localparam logic [15:0] WY_LAST = 16'(IN_H - 1);
  localparam logic [15:0] RX_LAST = 16'(OUT_W - 1);
  localparam logic [15:0] RY_LAST = 16'(OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] wx;
  logic [15:0] wy;
  logic [15:0] rx;
  logic [15:0] ry;
  logic        wr_done;
  logic        rd_done;

  logic        running;
  logic        launch;
  logic        wr_row_end;
  logic        wr_last;
  logic        rd_row_end;
  logic        rd_last;
  logic        rd_ok;
  logic        frame_end;

  assign running    = (state == RUN);
  assign launch     = (state == IDLE) && start;
  assign in_ready   = running && !wr_done;
  assign in_wen     = in_valid && in_ready;
  assign wr_row_end = (wx == WX_LAST);
  assign wr_last    = wr_row_end && (wy == WY_LAST);
  assign rd_row_end = (rx == RX_LAST);
  assign rd_last    = rd_row_end && (ry == RY_LAST);

`ifdef UPSAMPLE_SCHED_OVERLAP_EN
  // Completed source rows. Registered on purpose: a row becomes readable only
  // after its final write has been clocked into the buffer RAM.
  logic [15:0] rows_written;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_written <= '0;
    end else if (flush || launch) begin
      rows_written <= '0;
    end else if (in_wen && wr_row_end) begin
      rows_written <= rows_written + 16'd1;
    end
  end

  // Output row ry maps to source row ry >> SCALE_LOG2.
  assign rd_ok = rows_written > (ry >> SCALE_LOG2);
`else
  assign rd_ok = wr_done;
`endif

  assign out_ren = running && out_ready && rd_ok && !rd_done;

  assign in_ctrl_vars  = {wx, wy, 16'h0000};
  assign out_ctrl_vars = {rx, ry, 16'h0000};

  // Include the access completing this cycle so that done lands one cycle after it.
  assign frame_end = (wr_done || (in_wen && wr_last)) &&
                     (rd_done || (out_ren && rd_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wx      <= '0;
      wy      <= '0;
      rx      <= '0;
      ry      <= '0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wx      <= '0;
      wy      <= '0;
      rx      <= '0;
      ry      <= '0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            wx      <= '0;
            wy      <= '0;
            rx      <= '0;
            ry      <= '0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
          end
        end
        RUN: begin
          if (in_wen) begin
            if (wr_row_end) begin
              wx <= '0;
              wy <= wy + 16'd1;
            end else begin
              wx <= wx + 16'd1;
            end
            if (wr_last) begin
              wr_done <= 1'b1;
            end
          end
          if (out_ren) begin
            if (rd_row_end) begin
              rx <= '0;
              ry <= ry + 16'd1;
            end else begin
              rx <= rx + 16'd1;
            end
            if (rd_last) begin
              rd_done <= 1'b1;
            end
          end
          if (frame_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_sample_sched_ctrl.sv
// tb_up_sample_sched_ctrl: directed bench for up_sample_sched_ctrl with a 4x2 frame, x2 up-sample.
// Inputs are driven on the falling edge and outputs are sampled 1 time unit later.
// nw/nr count expected accesses, and the expected ctrl_vars are derived from those counts.
module tb_up_sample_sched_ctrl;

  localparam int IW = 4;
  localparam int IH = 2;
  localparam int SL = 1;
  localparam int OW = IW << SL;
`ifdef UPSAMPLE_SCHED_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  // First read cycle (counted from the start cycle) with free-flowing input and output.
  localparam int FR = OVL ? 5 : 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        in_wen;
  logic [47:0] in_ctrl_vars;
  logic        out_ren;
  logic [47:0] out_ctrl_vars;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_pass = 0;
  int nw = 0;
  int nr = 0;
  int fin = -1;
  int dn = 0;
  bit er;

  up_sample_sched_ctrl #(.IN_W(IW), .IN_H(IH), .SCALE_LOG2(SL)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wen       (in_wen),
    .in_ctrl_vars (in_ctrl_vars),
    .out_ready    (out_ready),
    .out_ren      (out_ren),
    .out_ctrl_vars(out_ctrl_vars),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [47:0] cv(input int row, input int col);
    return {col[15:0], row[15:0], 16'h0000};
  endfunction

  task automatic step_check(input string tag, input int c, input bit ew, input bit exr,
                            input bit ed, input bit eb);
    check($sformatf("%s c%0d wen", tag, c), in_wen, ew);
    check($sformatf("%s c%0d wcv", tag, c), in_ctrl_vars, cv(nw / IW, nw % IW));
    check($sformatf("%s c%0d ren", tag, c), out_ren, exr);
    check($sformatf("%s c%0d rcv", tag, c), out_ctrl_vars, cv(nr / OW, nr % OW));
    check($sformatf("%s c%0d done", tag, c), done, ed);
    check($sformatf("%s c%0d busy", tag, c), busy, eb);
    if (ew) nw++;
    if (exr) nr++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nw = 0;
    nr = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with traffic on both sides: nothing may leak out.
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst in_wen", in_wen, 0);
    check("rst out_ren", out_ren, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst in_cv", in_ctrl_vars, 0);
    check("rst out_cv", out_ctrl_vars, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle c%0d in_ready", c), in_ready, 0);
      step_check("idle", c, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Free-flowing frame.
    do_reset();
    for (int c = 0; c <= FR + 33; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      step_check("stream", c, (c >= 1 && c <= 8), (c >= FR && c < FR + 32),
                 (c == FR + 32), (c >= 1 && c < FR + 32));
    end

    // Input stalls after the first source row.
    do_reset();
    dn = OVL ? 45 : 61;
    for (int c = 0; c <= dn + 1; c++) begin
      @(negedge clk);
      start = (c == 0);
      in_valid = (c <= 4) || (c >= 25);
      #1;
      er = OVL ? ((c >= 5 && c <= 20) || (c >= 29 && c <= 44)) : (c >= 29 && c <= 60);
      step_check("stall", c, ((c >= 1 && c <= 4) || (c >= 25 && c <= 28)), er,
                 (c == dn), (c >= 1 && c < dn));
    end

    // Output backpressure with out_ready cycling 1,0,0,1.
    do_reset();
    fin = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = (c == 0);
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      er = out_ready && (c >= FR) && (nr < 32);
      step_check("bp", c, (c >= 1 && c <= 8), er, (fin >= 0 && c == fin + 1),
                 (c >= 1 && (fin < 0 || c <= fin)));
      if (er && nr == 32) fin = c;
      if (fin >= 0 && c == fin + 2) break;
    end
    check("bp finished", (fin >= 0), 1);

    // Ignored start in RUN, flush after 5 writes, then restart from (0,0).
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == 3) || (c == 8);
      flush = (c == 6);
      in_valid = (c != 6);
      #1;
      step_check("flush", c, ((c >= 1 && c <= 5) || c >= 9), 1'b0, 1'b0,
                 ((c >= 1 && c <= 6) || c >= 9));
      if (c == 6) nw = 0;
    end
    flush = 1'b0;
    start = 1'b0;

    // Asynchronous reset mid-frame, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst in_wen", in_wen, 0);
    check("arst in_ready", in_ready, 0);
    check("arst busy", busy, 0);
    check("arst in_cv", in_ctrl_vars, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/up_sample_sched_ctrl.md
# up_sample_sched_ctrl

Schedule controller for the up-sample pipeline. It sequences the frame-sized input buffer: it accepts an input pixel stream, generates the write enable and loop-variable (ctrl_vars) vectors for the input-stencil write port, and issues nearest-neighbor read requests at the up-scaled resolution. A read is issued only once the source input row has been fully written. The block sits between the input stream and the input-stencil buffer; its read port feeds the nearest-neighbor compute stage.

## Interface
Parameters:
- IN_W, 64, input frame width (pixels)
- IN_H, 64, input frame height (rows)
- SCALE_LOG2, 1, up-sample factor is 2^SCALE_LOG2 in each dimension; OUT_W = IN_W<<SCALE_LOG2, OUT_H = IN_H<<SCALE_LOG2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous restart; same effect as rst, taken at the next edge
- start  in  1  begins a frame; honored only in IDLE
- in_valid  in  1  upstream has a pixel
- in_ready  out  1  controller accepts a pixel
- in_wen  out  1  input-stencil write enable, equal to in_valid & in_ready
- in_ctrl_vars  out  3x16  write loop vars: [0]=0, [1]=input row, [2]=input column
- out_ready  in  1  downstream can take a read this cycle
- out_ren  out  1  nearest-neighbor read enable
- out_ctrl_vars  out  3x16  read loop vars: [0]=0, [1]=output row, [2]=output column (the buffer applies the floor-divide)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the last write and the last read are both complete.
  - DONE -> IDLE unconditionally after one cycle.
- Write counter (wy, wx):
  - Raster order: wx increments on each in_wen.
  - At wx = IN_W-1, wx wraps to 0 and wy increments.
  - wr_done is set after write IN_W*IN_H.
  - in_ready = RUN & !wr_done.
- rows_written counts completed input rows, 0..IN_H. It increments on the write with wx = IN_W-1.
- Read counter (ry, rx):
  - Raster order over OUT_W x OUT_H.
  - rd_ok = rows_written > (ry >> SCALE_LOG2).
  - out_ren = RUN & out_ready & rd_ok & !rd_done.
  - The counter advances only on out_ren.
  - rd_done is set after read OUT_W*OUT_H.
- Writes are never blocked by reads, because the buffer holds a full frame. Frame N+1 cannot start until DONE.
- All counters are 16-bit unsigned. ctrl_vars[0] is tied to 0.
- Counters and wr_done/rd_done clear on entry to RUN.
- start while in RUN or DONE is ignored.
- flush and rst dominate start.

## Timing
- Reset values:
  - state = IDLE.
  - All counters and rows_written = 0.
  - in_ready = in_wen = out_ren = busy = done = 0.
  - All ctrl_vars = 0.
- in_wen, in_ready and out_ren are combinational from registered state and the current inputs.
- ctrl_vars are registered counter values. They hold the address of the current access and change only after an accepted access.
- Read-after-write: the read of a row becomes legal the cycle after the last write of its source row. rows_written is registered, so no same-cycle bypass is used; the RAM write is clocked.
- If out_ready = 0, out_ren = 0 and out_ctrl_vars hold.
- Writes and reads may both fire in the same cycle.
- done is asserted in the DONE state, one cycle after the final access. busy is low in that cycle.
- Asynchronous rst mid-frame: the block goes to IDLE immediately and all outputs return to their reset values.

## Configuration
- UPSAMPLE_SCHED_OVERLAP_EN
  - Defined: reads overlap writes, gated row-by-row by rd_ok as above.
  - Undefined: two-phase schedule. rd_ok = wr_done, so no out_ren is issued until all IN_W*IN_H writes are done. Latency increases, and the read order and write order are unchanged.

## Test plan
- Reset:
  - Stimulus: assert rst with in_valid = out_ready = 1.
  - Required: all outputs 0 and state IDLE. After deassert, no activity occurs without start.
- Streaming (IN_W=4, IN_H=2, macro defined, in_valid = out_ready = 1, start pulse):
  - Writes go to (0,0)..(1,3) on 8 consecutive cycles.
  - First out_ren occurs the cycle after the 4th write.
  - Reads go to (0,0)..(3,7), 32 in total.
  - done pulses once, one cycle after read 32.
- Dependency stall (IN_W=4, IN_H=2, macro defined):
  - Stimulus: in_valid drops after 4 writes.
  - Required: exactly 16 reads (output rows 0-1), then out_ren stays 0 with out_ctrl_vars = (0,2,0) until the 8th write. Reads resume the following cycle.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1.
  - Required: out_ren follows out_ready, out_ctrl_vars hold during the low cycles, and no address is skipped or repeated.
- Macro undefined, same stimulus as the streaming case:
  - Required: out_ren stays 0 until the cycle after write 8, then 32 back-to-back reads, then done.
- Flush and ignored start:
  - Stimulus: flush after 5 writes; later, a start pulse while in RUN.
  - Required: after flush, the next cycle is IDLE with counters 0, and a new start restarts at (0,0). The start while in RUN leaves the counters unchanged.
